// File: rtl/rst_sequencer.sv
// rst_sequencer: releases NUM_DOM synchronous resets in ascending order after a filtered PLL lock.
// Define RST_SEQ_LOSS_CNT_EN to enable the saturating lock-loss counter on loss_cnt.
module rst_sequencer #(
    parameter int NUM_DOM     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILT   = 16,
    parameter int STEP_CYC    = 4
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               pll_lock,
    input  logic               force_rst,
    output logic [NUM_DOM-1:0] srst_n,
    output logic               rst_busy,
    output logic [7:0]         loss_cnt
);
    localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);

    typedef enum logic [1:0] {WAIT_LOCK, FILTER, RELEASE, RUN} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] lock_sync, force_sync;
    logic [FW-1:0]          filt_cnt, filt_nxt;
    logic [SW-1:0]          step_cnt, step_nxt;
    logic [NUM_DOM-1:0]     srst_nxt;
    logic                   lock_s, force_s, lock_ok;

    assign lock_s  = lock_sync[SYNC_STAGES-1];
    assign force_s = force_sync[SYNC_STAGES-1];
    assign lock_ok = lock_s && !force_s;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lock_sync  <= '0;
            force_sync <= '0;
        end else begin
            lock_sync  <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
            force_sync <= {force_sync[SYNC_STAGES-2:0], force_rst};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= WAIT_LOCK;
            filt_cnt <= '0;
            step_cnt <= '0;
            srst_n   <= '0;
            rst_busy <= 1'b1;
        end else begin
            state    <= state_nxt;
            filt_cnt <= filt_nxt;
            step_cnt <= step_nxt;
            srst_n   <= srst_nxt;
            rst_busy <= state_nxt != RUN;
        end
    end

    // srst_n doubles as the domain pointer: each step sets the next low-order bit.
    always_comb begin
        state_nxt = state;
        filt_nxt  = filt_cnt;
        step_nxt  = step_cnt;
        srst_nxt  = srst_n;
        case (state)
            WAIT_LOCK: begin
                srst_nxt = '0;
                if (lock_ok) begin
                    state_nxt = FILTER;
                    filt_nxt  = '0;
                end
            end
            FILTER: begin
                if (!lock_ok) state_nxt = WAIT_LOCK;
                else if (filt_cnt == FILT_LAST) begin
                    state_nxt = RELEASE;
                    step_nxt  = '0;
                end else filt_nxt = filt_cnt + 1'b1;
            end
            RELEASE: begin
                if (!lock_ok) begin
                    state_nxt = WAIT_LOCK;
                    srst_nxt  = '0;
                end else if (step_cnt == STEP_LAST) begin
                    srst_nxt  = (srst_n << 1) | NUM_DOM'(1);
                    step_nxt  = '0;
                    state_nxt = srst_nxt[NUM_DOM-1] ? RUN : RELEASE;
                end else step_nxt = step_cnt + 1'b1;
            end
            RUN: begin
                srst_nxt = '1;
                if (!lock_ok) begin
                    state_nxt = WAIT_LOCK;
                    srst_nxt  = '0;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

`ifdef RST_SEQ_LOSS_CNT_EN
    // Only a genuine lock drop counts; a force-only exit leaves the count alone.
    logic lost;
    assign lost = ((state == RELEASE) || (state == RUN)) && !lock_s;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) loss_cnt <= '0;
        else if (lost && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end
`else
    assign loss_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scoreboard bench; a lock-run-length reference model predicts every cycle.
module tb_rst_sequencer;
    localparam int ND = 3, SYNC = 2, LF = 16, STEP = 4;
`ifdef RST_SEQ_LOSS_CNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif
    localparam int REL0 = SYNC + LF + STEP + 1;

    logic clk = 1'b0, arst_n = 1'b1, pll_lock = 1'b0, force_rst = 1'b0;
    logic [ND-1:0] srst_n;
    logic          rst_busy;
    logic [7:0]    loss_cnt;
    int checks = 0, fails = 0;

    typedef struct packed {logic [ND-1:0] s; logic b; logic [7:0] l;} exp_t;
    exp_t sb[$];
    bit   hl[$], hf[$];
    int   n = 0, loss = 0;

    rst_sequencer #(.NUM_DOM(ND), .SYNC_STAGES(SYNC), .LOCK_FILT(LF), .STEP_CYC(STEP)) dut (
        .clk(clk), .arst_n(arst_n), .pll_lock(pll_lock), .force_rst(force_rst),
        .srst_n(srst_n), .rst_busy(rst_busy), .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hl.delete();
        hf.delete();
        for (int i = 0; i < SYNC; i++) begin
            hl.push_back(1'b0);
            hf.push_back(1'b0);
        end
        sb.delete();
        n = 0;
        loss = 0;
    endfunction

    initial model_reset();
    always @(negedge arst_n) model_reset();

    // n = consecutive edges with lock_ok high; release count follows from n directly.
    always @(posedge clk) begin : model
        bit   ls, fs;
        int   r;
        exp_t e;
        if (arst_n) begin
            ls = hl[SYNC-1];
            fs = hf[SYNC-1];
            hl.push_front(pll_lock);
            hl.delete(SYNC);
            hf.push_front(force_rst);
            hf.delete(SYNC);
            if (ls && !fs) begin
                if (n < 1000000) n++;
            end else begin
                if (n >= LF + 1 && !ls && LOSS_EN == 1) loss = (loss < 255) ? loss + 1 : 255;
                n = 0;
            end
            r = (n > LF + 1) ? (n - LF - 1) / STEP : 0;
            if (r > ND) r = ND;
            e.s = ND'((1 << r) - 1);
            e.b = r < ND;
            e.l = 8'(loss);
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!arst_n) begin
            chk("rst_srst_n", int'(srst_n), 0);
            chk("rst_busy", int'(rst_busy), 1);
            chk("rst_loss", int'(loss_cnt), 0);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("srst_n", int'(srst_n), int'(e.s));
            chk("rst_busy", int'(rst_busy), int'(e.b));
            chk("loss_cnt", int'(loss_cnt), int'(e.l));
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        pll_lock  = 1'b0;
        force_rst = 1'b0;
        #1 arst_n = 1'b0;
        step(3);
        arst_n = 1'b1;
    endtask

    task automatic measure(input string tag);
        int e0 = -1, e1 = -1, e2 = -1, eb = -1;
        for (int k = 1; k <= 60 && eb < 0; k++) begin
            @(posedge clk);
            #1;
            if (e0 < 0 && srst_n[0]) e0 = k;
            if (e1 < 0 && srst_n[1]) e1 = k;
            if (e2 < 0 && srst_n[2]) e2 = k;
            if (eb < 0 && !rst_busy) eb = k;
        end
        chk({tag, "_rel0"}, e0, REL0);
        chk({tag, "_rel1"}, e1, REL0 + STEP);
        chk({tag, "_rel2"}, e2, REL0 + 2 * STEP);
        chk({tag, "_busy_fall"}, eb, REL0 + 2 * STEP);
    endtask

    task automatic wait_rel0(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (srst_n[0]) ok = 1'b1;
            else step(1);
        end
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (!rst_busy) ok = 1'b1;
            else step(1);
        end
    endtask

    initial begin : watchdog
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1);
    end

    initial begin : stim
        bit ok;
        int prev, d, timeouts;
        #1 arst_n = 1'b0;
        step(3);
        arst_n = 1'b1;
        pll_lock = 1'b1;
        measure("seq");

        do_reset();
        pll_lock = 1'b1;
        step(10);
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        measure("glitch");

        do_reset();
        pll_lock = 1'b1;
        measure("run");
        prev = int'(loss_cnt);
        pll_lock = 1'b0;
        d = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) pll_lock = 1'b1;
            if (d < 0 && srst_n == '0) d = k;
        end
        chk("drop_edge", d, 3);
        chk("drop_loss", int'(loss_cnt), prev + LOSS_EN);
        wait_rel0(ok);
        chk("reseq_rel0_reached", int'(ok), 1);

        prev = int'(loss_cnt);
        force_rst = 1'b1;
        step(1);
        force_rst = 1'b0;
        step(2);
        chk("force_srst_n", int'(srst_n), 0);
        chk("force_busy", int'(rst_busy), 1);
        chk("force_loss", int'(loss_cnt), prev);
        wait_run(ok);
        chk("force_recover_run", int'(ok), 1);

        pll_lock = 1'b0;
        step(4);
        pll_lock = 1'b1;
        wait_rel0(ok);
        chk("arst_rel0_reached", int'(ok), 1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_async_srst_n", int'(srst_n), 0);
        chk("arst_async_busy", int'(rst_busy), 1);
        @(posedge clk);
        #1 arst_n = 1'b1;
        measure("arst");

        do_reset();
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            wait_rel0(ok);
            if (!ok) timeouts++;
            pll_lock = 1'b0;
            step(3);
        end
        chk("loss_loop_timeouts", timeouts, 0);
        chk("loss_saturated", int'(loss_cnt), 255 * LOSS_EN);

        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            pll_lock  = $urandom_range(0, 3) != 0;
            force_rst = $urandom_range(0, 9) == 0;
            step($urandom_range(1, 45));
            if ($urandom_range(0, 24) == 0) begin
                #2 arst_n = 1'b0;
                step(2);
                arst_n = 1'b1;
            end
        end
        pll_lock  = 1'b0;
        force_rst = 1'b0;
        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
